// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 round controller.
//
// Contents:
//   AES_BLOCK_W       state / round-key width in bits
//   AES_NUM_ROUNDS    number of rounds after the initial key addition
//   AES_FINAL_ROUND   round index on which mix_columns is bypassed
//   aes_state_e       controller FSM states
//   aes_round_state_t 5-bit round state consumed by mix_columns ({active, index})
package aes_pkg;

  localparam int unsigned AES_BLOCK_W     = 128;
  localparam int unsigned AES_NUM_ROUNDS  = 10;
  localparam logic [3:0]  AES_FINAL_ROUND = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StKey0  = 2'd1,
    StRound = 2'd2,
    StDone  = 2'd3
  } aes_state_e;

  typedef struct packed {
    logic       active;
    logic [3:0] idx;
  } aes_round_state_t;

endpackage

// File: rtl/add_round_key.sv
// AddRoundKey: combinational XOR of a data block with a round key.
//
// Ports:
//   data    block to be keyed
//   key     round key
//   result  data ^ key
module add_round_key #(
  parameter int unsigned BLOCK_W = 128
) (
  input  logic [BLOCK_W-1:0] data,
  input  logic [BLOCK_W-1:0] key,
  output logic [BLOCK_W-1:0] result
);

  assign result = data ^ key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption round controller and state register.
//
// Holds the cipher state, performs the initial key addition followed by NUM_ROUNDS rounds,
// and drives the round state used by mix_columns. SubBytes/ShiftRows/mix_columns live
// outside: o_round_data feeds them and i_mix_data returns their result.
//
// Ports:
//   clk, n_rst      clock (rising edge) and asynchronous active-low reset
//   i_start         start pulse, accepted only when idle
//   i_plaintext     input block, captured when i_start is accepted
//   o_busy          high whenever not idle
//   o_key_req       round key requested for o_key_idx
//   o_key_idx       requested round key index 0..10
//   i_key_valid     i_round_key is valid for o_key_idx this cycle
//   i_round_key     round key from the key schedule
//   o_round_data    current cipher state
//   o_round_state   {active, round index} for mix_columns
//   i_mix_data      mix_columns output for the current round
//   o_valid         ciphertext valid
//   o_ciphertext    result block (zero unless o_valid)
//   i_ready         consumer accepts the ciphertext
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned BLOCK_W    = AES_BLOCK_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_start,
  input  logic [BLOCK_W-1:0] i_plaintext,
  output logic               o_busy,
  output logic               o_key_req,
  output logic [3:0]         o_key_idx,
  input  logic               i_key_valid,
  input  logic [BLOCK_W-1:0] i_round_key,
  output logic [BLOCK_W-1:0] o_round_data,
  output logic [4:0]         o_round_state,
  input  logic [BLOCK_W-1:0] i_mix_data,
  output logic               o_valid,
  output logic [BLOCK_W-1:0] o_ciphertext,
  input  logic               i_ready
);

  // Only AES-128 (10 rounds) is supported; the last round index follows from it.
  localparam logic [3:0] FinalRound = 4'(NUM_ROUNDS - 1);

  aes_state_e       state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [3:0]       round_q, round_d;

  logic [BLOCK_W-1:0] ark_in;
  logic [BLOCK_W-1:0] ark_out;
  aes_round_state_t   round_state;

  // One XOR serves both paths: the raw state during the initial key addition, the
  // mix_columns result during the rounds.
  assign ark_in = (state_q == StKey0) ? data_q : i_mix_data;

  add_round_key #(
    .BLOCK_W (BLOCK_W)
  ) u_add_round_key (
    .data   (ark_in),
    .key    (i_round_key),
    .result (ark_out)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StKey0;
      StKey0:  if (i_key_valid) state_d = StRound;
      StRound: if (i_key_valid && (round_q == FinalRound)) state_d = StDone;
      StDone:  if (i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; everything holds while the key schedule stalls.
  always_comb begin
    data_d  = data_q;
    round_d = round_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          data_d  = i_plaintext;
          round_d = '0;
        end
      end
      StKey0: begin
        if (i_key_valid) begin
          data_d  = ark_out;
          round_d = '0;
        end
      end
      StRound: begin
        if (i_key_valid) begin
          data_d = ark_out;
          // The counter parks at the final index instead of wrapping.
          if (round_q != FinalRound) round_d = round_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      round_q <= '0;
    end else begin
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  // Output decode.
  always_comb begin
    o_busy       = (state_q != StIdle);
    o_key_req    = 1'b0;
    o_key_idx    = 4'd0;
    round_state  = '0;
    o_valid      = 1'b0;
    o_ciphertext = '0;
    unique case (state_q)
      StIdle: ;
      StKey0: begin
        o_key_req = 1'b1;
      end
      StRound: begin
        o_key_req          = 1'b1;
        o_key_idx          = round_q + 4'd1;
        round_state.active = 1'b1;
        round_state.idx    = round_q;
      end
      StDone: begin
        o_valid      = 1'b1;
        o_ciphertext = data_q;
      end
      default: ;
    endcase
  end

  assign o_round_state = round_state;
  assign o_round_data  = data_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Surrounds the controller with behavioural
// SubBytes/ShiftRows/MixColumns and an AES-128 key schedule, and checks against the
// FIPS-197 C.1 vector.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ALT_PT = 128'hdeadbeef0badf00dcafebabe12345678;

  logic         clk;
  logic         n_rst;
  logic         i_start;
  logic [127:0] i_plaintext;
  logic         o_busy;
  logic         o_key_req;
  logic [3:0]   o_key_idx;
  logic         i_key_valid;
  logic [127:0] i_round_key;
  logic [127:0] o_round_data;
  logic [4:0]   o_round_state;
  logic [127:0] i_mix_data;
  logic         o_valid;
  logic [127:0] o_ciphertext;
  logic         i_ready;

  int checks;
  int errors;

  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];

  aes_round_ctrl #(
    .NUM_ROUNDS (10),
    .BLOCK_W    (128)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .i_start       (i_start),
    .i_plaintext   (i_plaintext),
    .o_busy        (o_busy),
    .o_key_req     (o_key_req),
    .o_key_idx     (o_key_idx),
    .i_key_valid   (i_key_valid),
    .i_round_key   (i_round_key),
    .o_round_data  (o_round_data),
    .o_round_state (o_round_state),
    .i_mix_data    (i_mix_data),
    .o_valid       (o_valid),
    .o_ciphertext  (o_ciphertext),
    .i_ready       (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) plus the affine transform; key schedule after.
  task automatic build_tables();
    logic [7:0]  inv;
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
      sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
            ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // SubBytes + ShiftRows + MixColumns, with MixColumns bypassed on round state 5'b11001.
  function automatic logic [127:0] env_mix(input logic [127:0] s, input logic [4:0] rs);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] res;
    for (int j = 0; j < 16; j++) a[j] = sbox[s[127-8*j -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    if (rs != 5'b11001) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
        b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
        b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
        b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
      end
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = b[j];
    return res;
  endfunction

  // Called on the falling edge: present key and mix result for the current outputs.
  task automatic drive_env();
    i_round_key = (o_key_idx <= 4'd10) ? rk[o_key_idx] : 128'h0;
    i_mix_data  = env_mix(o_round_data, o_round_state);
  endtask

  // Full encryption of PT with optional key stalls, back-pressure and stray start pulses.
  task automatic encrypt(input string tag, input int stall_k0, input int stall_r5,
                         input int ready_delay, input bit pulse_start, input bit log_seq,
                         input bit start_with_ready);
    int           cyc;
    int           k0_cnt;
    int           r5_cnt;
    bit           r5_prev;
    bit           got;
    logic [127:0] r5_data;
    logic [4:0]   exp_rs;
    @(negedge clk);
    i_plaintext = PT;
    i_start     = 1'b1;
    i_ready     = 1'b0;
    i_key_valid = 1'b1;
    drive_env();
    @(negedge clk);
    i_start     = 1'b0;
    i_plaintext = '0;
    cyc = 1; k0_cnt = 0; r5_cnt = 0; r5_prev = 1'b0; got = 1'b0; r5_data = '0;
    while (cyc < 60) begin
      if (o_valid) begin
        got = 1'b1;
        break;
      end
      if (log_seq) begin
        exp_rs = (cyc == 1) ? 5'b00000 : {1'b1, 4'(cyc - 2)};
        checks++;
        if (o_key_idx !== 4'(cyc - 1) || o_key_req !== 1'b1) begin
          errors++;
          $display("FAIL %s key_idx cycle %0d: got idx %0d req %b, expected idx %0d req 1",
                   tag, cyc, o_key_idx, o_key_req, cyc - 1);
        end
        checks++;
        if (o_round_state !== exp_rs) begin
          errors++;
          $display("FAIL %s round_state cycle %0d: got %b expected %b",
                   tag, cyc, o_round_state, exp_rs);
        end
      end
      if (r5_prev) begin
        checks++;
        if (o_round_state !== 5'b10101 || o_round_data !== r5_data) begin
          errors++;
          $display("FAIL %s round5 stall hold: got state %b data %h, expected 10101 data %h",
                   tag, o_round_state, o_round_data, r5_data);
        end
      end
      r5_prev = 1'b0;
      if (o_key_req && o_key_idx == 4'd0 && k0_cnt < stall_k0) begin
        i_key_valid = 1'b0;
        k0_cnt++;
      end else if (o_round_state == 5'b10101 && r5_cnt < stall_r5) begin
        i_key_valid = 1'b0;
        r5_cnt++;
        r5_prev = 1'b1;
        r5_data = o_round_data;
      end else begin
        i_key_valid = 1'b1;
      end
      if (pulse_start && cyc == 4) begin
        i_start     = 1'b1;
        i_plaintext = ALT_PT;
      end else begin
        i_start     = 1'b0;
        i_plaintext = '0;
      end
      drive_env();
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: o_valid never rose, got 0 expected 1", tag);
      return;
    end
    checks++;
    if (cyc - 1 !== 11 + stall_k0 + stall_r5) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", tag, cyc - 1,
               11 + stall_k0 + stall_r5);
    end
    checks++;
    if (o_ciphertext !== CT) begin
      errors++;
      $display("FAIL %s ciphertext: got %h expected %h", tag, o_ciphertext, CT);
    end
    if (log_seq) begin
      checks++;
      if (o_round_state !== 5'b00000 || o_key_req !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s done outputs: got rs %b req %b busy %b expected 00000 0 1",
                 tag, o_round_state, o_key_req, o_busy);
      end
    end
    for (int d = 0; d < ready_delay; d++) begin
      i_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_ciphertext !== CT) begin
        errors++;
        $display("FAIL %s backpressure hold %0d: got valid %b ct %h expected 1 %h",
                 tag, d, o_valid, o_ciphertext, CT);
      end
    end
    i_ready = 1'b1;
    i_start = start_with_ready;
    i_plaintext = ALT_PT;
    @(negedge clk);
    i_ready = 1'b0;
    i_start = 1'b0;
    i_plaintext = '0;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL %s release to idle: got busy %b valid %b ct %h expected 0 0 0",
               tag, o_busy, o_valid, o_ciphertext);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s stay idle: got busy %b expected 0", tag, o_busy);
    end
  endtask

  task automatic test_reset();
    n_rst       = 1'b0;
    i_start     = 1'b1;
    i_plaintext = PT;
    i_key_valid = 1'b1;
    i_round_key = KEY;
    i_mix_data  = PT;
    i_ready     = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_key_req !== 1'b0) begin
      errors++;
      $display("FAIL reset flags: got busy %b valid %b req %b expected 0 0 0",
               o_busy, o_valid, o_key_req);
    end
    checks++;
    if (o_round_data !== 128'h0 || o_ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL reset data: got data %h ct %h expected 0 0", o_round_data, o_ciphertext);
    end
    checks++;
    if (o_key_idx !== 4'd0 || o_round_state !== 5'd0) begin
      errors++;
      $display("FAIL reset idx: got idx %0d rs %b expected 0 00000", o_key_idx, o_round_state);
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    n_rst   = 1'b1;
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_round_data !== 128'h0) begin
      errors++;
      $display("FAIL idle after reset: got busy %b data %h expected 0 0", o_busy, o_round_data);
    end
  endtask

  task automatic test_fips_vector();
    encrypt("fips", 0, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_key_stalls();
    encrypt("stall", 3, 2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_pressure();
    encrypt("backpressure", 0, 0, 5, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset_mid_round();
    int cyc;
    @(negedge clk);
    i_plaintext = PT;
    i_start     = 1'b1;
    i_key_valid = 1'b1;
    i_ready     = 1'b0;
    drive_env();
    @(negedge clk);
    i_start = 1'b0;
    cyc = 0;
    while (o_round_state !== 5'b10100 && cyc < 40) begin
      drive_env();
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (o_round_state !== 5'b10100) begin
      errors++;
      $display("FAIL arst reach round4: got rs %b expected 10100", o_round_state);
    end
    drive_env();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_round_data !== 128'h0) begin
      errors++;
      $display("FAIL arst immediate: got busy %b valid %b data %h expected 0 0 0",
               o_busy, o_valid, o_round_data);
    end
    checks++;
    if (o_key_req !== 1'b0 || o_round_state !== 5'd0 || o_key_idx !== 4'd0) begin
      errors++;
      $display("FAIL arst decode: got req %b rs %b idx %0d expected 0 00000 0",
               o_key_req, o_round_state, o_key_idx);
    end
    @(negedge clk);
    n_rst = 1'b1;
    encrypt("after_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    n_rst       = 1'b0;
    i_start     = 1'b0;
    i_plaintext = '0;
    i_key_valid = 1'b0;
    i_round_key = '0;
    i_mix_data  = '0;
    i_ready     = 1'b0;
    build_tables();
    test_reset();
    test_fips_vector();
    test_key_stalls();
    test_back_pressure();
    test_async_reset_mid_round();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption round controller and state register that sits directly around mix_columns. It holds the 128-bit cipher state, sequences the initial key addition plus 10 rounds, and drives the 5-bit round state that mix_columns uses to bypass on the final round. It consumes mix_columns output, XORs in the round key, and registers the result. SubBytes/ShiftRows sit combinationally between o_round_data and the mix_columns input, outside this block.

Parameters:
NUM_ROUNDS, 10, round count after initial key add; only 10 (AES-128) is supported.
BLOCK_W, 128, state/key width in bits.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous reset, active-low
i_start  in  1  start pulse; sampled only in IDLE
i_plaintext  in  128  input block, captured when i_start is accepted
o_busy  out  1  high in every state except IDLE
o_key_req  out  1  round key requested for index o_key_idx
o_key_idx  out  4  requested key index 0..10
i_key_valid  in  1  i_round_key is valid for o_key_idx this cycle
i_round_key  in  128  round key from the key schedule
o_round_data  out  128  current state register, feeds SubBytes/ShiftRows
o_round_state  out  5  [4]=round active, [3:0]=round index 0..9, drives mix_columns i_state
i_mix_data  in  128  mix_columns output for the current round
o_valid  out  1  ciphertext valid
o_ciphertext  out  128  result block, equal to the state register in DONE
i_ready  in  1  consumer accepts the ciphertext

Behaviour:
- Reset (n_rst=0, asynchronous): state=IDLE, state register=0, round=0, all outputs 0.
- FSM states: IDLE, KEY0, ROUND, DONE. Encoding is defined in aes_pkg.
- IDLE: o_busy=0, o_key_req=0. If i_start=1 at a clock edge: state_reg<=i_plaintext, go to KEY0.
- KEY0: o_key_req=1, o_key_idx=0, o_round_state=5'b0.
  - If i_key_valid=1: state_reg<=state_reg^i_round_key, round<=0, go to ROUND.
  - Otherwise hold.
- ROUND: o_key_req=1, o_key_idx=round+1, o_round_state={1'b1, round}.
  - If i_key_valid=1: state_reg<=i_mix_data^i_round_key.
  - Then, if round==NUM_ROUNDS-1 (9), go to DONE; otherwise round<=round+1.
  - If i_key_valid=0: hold everything; the round index and state are stable.
- Round 9 relies on mix_columns bypass (i_state[3:0]=9), so i_mix_data equals the ShiftRows output on that round.
- DONE: o_valid=1, o_ciphertext=state_reg, o_key_req=0, o_round_state=5'b0.
  - If i_ready=1: go to IDLE; o_valid drops next cycle.
  - Otherwise hold; the ciphertext stays stable.
- Outputs outside DONE: o_valid=0 and o_ciphertext=0.
- Latency: with i_key_valid tied high, i_start accepted at edge E gives o_valid=1 after edge E+11. Each low i_key_valid cycle adds one cycle.
- i_start outside IDLE is ignored; there is no queuing.
- DONE with i_ready=1 and i_start=1 in the same cycle: go to IDLE; that i_start is not accepted.
- Round counter width is 4 bits and never exceeds 9; no wrap.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0. There is no partial-result output.
- o_round_data always equals state_reg, in every state.
- All logic is registered except the key XOR and the output decode.

Decomposition:
- Package aes_pkg holds:
  - the FSM state enum type (IDLE, KEY0, ROUND, DONE);
  - localparams AES_BLOCK_W=128, AES_NUM_ROUNDS=10, AES_FINAL_ROUND=4'd9;
  - the 5-bit round-state typedef shared with mix_columns.
- One natural sub-module: add_round_key (128-bit XOR of data and key, combinational). It is reused for both the KEY0 and ROUND paths via an input mux.

Test Plan:
- FIPS-197 C.1 vector. Wire the bench to SubBytes/ShiftRows/mix_columns and a key-schedule model. Use plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f, with i_key_valid always 1 and i_start at edge E. Required: o_valid at E+11 and o_ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key stalls: use the same vector with i_key_valid deasserted for 3 cycles in KEY0 and 2 cycles in round 5. Required: o_valid at E+16, same ciphertext, and o_round_state holds 5'b10101 throughout the round-5 stall.
- Back-pressure: hold i_ready=0 for 5 cycles after o_valid. Required: o_valid and o_ciphertext stable for those cycles, and IDLE one cycle after i_ready=1. Also pulse i_start during the busy period; it must be ignored.
- Round sequencing: log o_key_idx and o_round_state per cycle. Required: key_idx 0,1..10; round_state 00000, then 10000..11001, then 00000 in DONE.
- Async reset mid-round: drop n_rst during round 4, off clock edge. Required: o_busy=0, o_valid=0, o_round_data=0 immediately. A new start afterwards must produce the correct C.1 ciphertext.
